flash_op_ctrl: RTL

Initiator-side sequencer for the generic flash macro. Accepts one high-level operation (read N words, program N words, page erase, bank erase), breaks it into single-word flash primitive transactions on the macro's req/rd/prog/erase interface, streams program data in and read data out over valid/ready, and reports completion. It sits between the flash controller register/FIFO logic and the flash macro wrapper.

---
 rtl/flash_ctrl_pkg.sv | 29 ++
 rtl/flash_rd_buf.sv | 27 ++
 rtl/flash_op_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/flash_ctrl_pkg.sv
// rtl/flash_ctrl_pkg.sv - shared types and geometry for the flash operation sequencer
package flash_ctrl_pkg;

  localparam int PagesPerBank = 256;
  localparam int WordsPerPage = 256;
  localparam int DataWidth    = 32;
  localparam int PageW        = $clog2(PagesPerBank);
  localparam int WordW        = $clog2(WordsPerPage);
  localparam int AddrW        = PageW + WordW;

  typedef enum logic [1:0] {
    OpRead    = 2'd0,
    OpProg    = 2'd1,
    OpPgErase = 2'd2,
    OpBkErase = 2'd3
  } op_type_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFetch  = 2'd1,
    StAccess = 2'd2,
    StDone   = 2'd3
  } state_e;

  function automatic logic is_erase(input op_type_e t);
    return (t == OpPgErase) || (t == OpBkErase);
  endfunction

endpackage

// File: rtl/flash_rd_buf.sv
// rtl/flash_rd_buf.sv - single-entry valid/ready holding register for read data
module flash_rd_buf
  import flash_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rvalid_o,
  input  logic                 rready_i
);

  // The sequencer only loads when the entry is empty, so load simply wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else if (load_i) begin
      rdata_o  <= data_i;
      rvalid_o <= 1'b1;
    end else if (rvalid_o && rready_i) begin
      rvalid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/flash_op_ctrl.sv
// rtl/flash_op_ctrl.sv - splits read/program/erase operations into single-word flash primitives
module flash_op_ctrl
  import flash_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 op_ready_o,
  input  logic                 op_start_i,
  input  logic [1:0]           op_type_i,
  input  logic [AddrW-1:0]     op_addr_i,
  input  logic [WordW-1:0]     op_num_i,
  output logic                 op_busy_o,
  output logic                 op_done_o,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic                 flash_req_o,
  output logic                 flash_rd_o,
  output logic                 flash_prog_o,
  output logic                 flash_pg_erase_o,
  output logic                 flash_bk_erase_o,
  output logic [AddrW-1:0]     flash_addr_o,
  output logic [DataWidth-1:0] flash_prog_data_o,
  input  logic                 flash_rd_done_i,
  input  logic                 flash_prog_done_i,
  input  logic                 flash_erase_done_i,
  input  logic [DataWidth-1:0] flash_rd_data_i,
  input  logic                 flash_init_busy_i
);

  state_e               state_q, state_d;
  op_type_e             type_q;
  logic [AddrW-1:0]     addr_q;
  logic [WordW-1:0]     remaining_q;
  logic [DataWidth-1:0] prog_data_q;
  logic                 start_ok;
  logic                 done_hit;
  logic                 rd_load;

  assign op_ready_o        = (state_q == StIdle) && !flash_init_busy_i;
  assign op_busy_o         = (state_q != StIdle);
  assign start_ok          = op_start_i && op_ready_o;
  assign flash_addr_o      = addr_q;
  assign flash_prog_data_o = prog_data_q;

  // Only the completion that matches the latched operation advances the sequence.
  always_comb begin
    done_hit = 1'b0;
    if (state_q == StAccess) begin
      case (type_q)
        OpRead:  done_hit = flash_rd_done_i;
        OpProg:  done_hit = flash_prog_done_i;
        default: done_hit = flash_erase_done_i;
      endcase
    end
  end

  assign rd_load = done_hit && (type_q == OpRead);

  always_comb begin
    state_d          = state_q;
    wready_o         = 1'b0;
    op_done_o        = 1'b0;
    flash_req_o      = 1'b0;
    flash_rd_o       = 1'b0;
    flash_prog_o     = 1'b0;
    flash_pg_erase_o = 1'b0;
    flash_bk_erase_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_ok) state_d = is_erase(op_type_e'(op_type_i)) ? StAccess : StFetch;
      end
      StFetch: begin
        if (type_q == OpProg) begin
          wready_o = 1'b1;
          if (wvalid_i) state_d = StAccess;
        end else if (!rvalid_o || rready_i) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        flash_req_o      = 1'b1;
        flash_rd_o       = (type_q == OpRead);
        flash_prog_o     = (type_q == OpProg);
        flash_pg_erase_o = (type_q == OpPgErase);
        flash_bk_erase_o = (type_q == OpBkErase);
        if (done_hit) state_d = (is_erase(type_q) || remaining_q == '0) ? StDone : StFetch;
      end
      StDone: begin
        op_done_o = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      type_q      <= OpRead;
      addr_q      <= '0;
      remaining_q <= '0;
      prog_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        type_q      <= op_type_e'(op_type_i);
        addr_q      <= op_addr_i;
        remaining_q <= op_num_i;
      end
      if (wready_o && wvalid_i) prog_data_q <= wdata_i;
      // Address wraps across pages and the top of the array.
      if (done_hit && state_d == StFetch) begin
        remaining_q <= remaining_q - WordW'(1);
        addr_q      <= addr_q + AddrW'(1);
      end
    end
  end

  flash_rd_buf u_rd_buf (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (rd_load),
    .data_i   (flash_rd_data_i),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .rready_i (rready_i)
  );

endmodule
